// File: rtl/tl_sram_slave_if.sv
// tilelink: single-beat TileLink-UL channel A / channel D bundle.
//   slave modport : consumes A (a_valid, a_opcode, a_size, a_source, a_address,
//                   a_mask, a_data), drives a_ready; drives all D fields
//                   (d_valid, d_opcode, d_size, d_source, d_data, d_denied),
//                   consumes d_ready.
//   master modport: the mirror image.
interface tilelink;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic [63:0] d_data;
    logic        d_denied;

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        input  d_ready
    );

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data, d_denied,
        output d_ready
    );
endinterface

// File: rtl/tl_sram_slave.sv
// tl_sram_slave: TileLink-UL responder in front of a 64-bit-wide on-chip SRAM.
// Accepts one single-beat Get/PutFullData/PutPartialData on channel A, waits
// LATENCY cycles, then returns AccessAck / AccessAckData on channel D.
//
// Parameters:
//   DEPTH   - number of 64-bit words (power of two, >= 2)
//   LATENCY - cycles from A handshake edge to d_valid high (1..15)
// Ports:
//   clk   - clock, all state changes on rising edge
//   rst_n - asynchronous active-low reset
//   bus   - tilelink.slave (channel A in, channel D out)
//
// Optional feature macro: TL_SRAM_ERR_EN
//   defined   : address bits above the word index must be zero and the opcode
//               must be supported, otherwise d_denied=1, d_data=0, no write.
//   undefined : high address bits alias, d_denied is always 0.
module tl_sram_slave #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    tilelink.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] TL_PUT_FULL      = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL   = 3'd1;
    localparam logic [2:0] TL_GET           = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK    = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_D  = 3'd1;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        live_q;
    logic [3:0]  cnt_q;

    logic        a_ready_c;
    logic        d_valid_c;
    logic        a_fire;
    logic        d_fire;

    logic [AW-1:0] idx;
    logic          is_get;
    logic          is_put;
    logic          req_denied;
    logic          do_write;
    logic          unused_addr_bits;

    logic [2:0]  d_opcode_q;
    logic [2:0]  d_size_q;
    logic [3:0]  d_source_q;
    logic [63:0] d_data_q;
    logic        d_denied_q;

    logic [63:0] mem [DEPTH];

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    assign idx    = bus.a_address[3+AW-1:3];
    assign is_get = (bus.a_opcode == TL_GET);
    assign is_put = (bus.a_opcode == TL_PUT_FULL) || (bus.a_opcode == TL_PUT_PARTIAL);

`ifdef TL_SRAM_ERR_EN
    assign req_denied       = (|bus.a_address[63:3+AW]) || !(is_get || is_put);
    assign unused_addr_bits = ^bus.a_address[2:0];
`else
    assign req_denied       = 1'b0;
    assign unused_addr_bits = ^{bus.a_address[63:3+AW], bus.a_address[2:0]};
`endif

    assign a_fire   = bus.a_valid && a_ready_c;
    assign d_fire   = d_valid_c && bus.d_ready;
    assign do_write = a_fire && is_put && !req_denied;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    // live_q holds a_ready low while in reset and releases it on the
    // first clock edge after deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (a_fire) begin
                    state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (d_fire) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        a_ready_c = (state_q == S_IDLE) && live_q;
        d_valid_c = (state_q == S_RESP);
    end

    // ---------------------------------------------------------------
    // Latency counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (a_fire) begin
            cnt_q <= LAT_M1;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // ---------------------------------------------------------------
    // Response capture: all D fields are latched at the A handshake and
    // held untouched until the next request, so a stalled D beat is stable.
    // Read data is taken before the same-edge write, but a Get never writes.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_opcode_q <= '0;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_denied_q <= 1'b0;
        end else if (a_fire) begin
            d_opcode_q <= is_get ? TL_ACCESS_ACK_D : TL_ACCESS_ACK;
            d_size_q   <= bus.a_size;
            d_source_q <= bus.a_source;
            d_data_q   <= (is_get && !req_denied) ? mem[idx] : '0;
            d_denied_q <= req_denied;
        end
    end

    // ---------------------------------------------------------------
    // SRAM array (not reset); byte-lane write enables from a_mask
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (bus.a_mask[i]) begin
                    mem[idx][8*i +: 8] <= bus.a_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.a_ready  = a_ready_c;
    assign bus.d_valid  = d_valid_c;
    assign bus.d_opcode = d_opcode_q;
    assign bus.d_size   = d_size_q;
    assign bus.d_source = d_source_q;
    assign bus.d_data   = d_data_q;
    assign bus.d_denied = d_denied_q;

endmodule

// File: doc/tl_sram_slave.md
# tl_sram_slave

TileLink-UL responder that serves the instruction cache's refill Gets and other single-beat Get/Put traffic from an on-chip 64-bit-wide SRAM. It accepts one request on channel A, holds it for a programmable access latency, then returns AccessAck/AccessAckData on channel D. It sits on the slave side of the `tilelink` interface, opposite the fetch and data masters.

## Interface
- `DEPTH`, 1024: number of 64-bit words; power of two, ≥2; index = `a_address[3+AW-1:3]`, AW = log2(DEPTH)
- `LATENCY`, 1: cycles from A handshake edge to `d_valid` high; legal range 1..15
- `clk`  input  1  clock; all state changes on rising edge
- `rst_n`  input  1  reset; asynchronous, active-low
- `bus`  tilelink.slave  —  A: `a_valid`, `a_ready` (out), `a_opcode[2:0]`, `a_size[2:0]`, `a_source[3:0]`, `a_address[63:0]`, `a_mask[7:0]`, `a_data[63:0]`; D: `d_valid` (out), `d_ready`, `d_opcode[2:0]`, `d_size[2:0]`, `d_source[3:0]`, `d_data[63:0]`, `d_denied` (all D fields out)

## Operation
- Opcodes: A: PutFullData=0, PutPartialData=1, Get=4 (`TL_GET`); D: AccessAck=0, AccessAckData=1.
- States: S_IDLE (`a_ready`=1), S_WAIT (latency counter running), S_RESP (`d_valid`=1).
- S_IDLE: `a_valid` high → capture opcode, size, source, word index, response data; go S_RESP if LATENCY=1, else S_WAIT with `cnt`=LATENCY-1.
- S_WAIT: `cnt` decrements each cycle; at `cnt`=1 next state S_RESP.
- S_RESP: hold all D fields stable until `d_ready`; on `d_valid & d_ready` → S_IDLE.
- Get: `d_opcode`=1, `d_data`=full 64-bit word at index (no lane shifting; master selects bytes), `d_size`=`a_size`, `d_source`=`a_source`.
- PutFullData/PutPartialData: byte i of word written from `a_data[8i+7:8i]` iff `a_mask[i]`; write commits on the A handshake edge; `d_opcode`=0, `d_data`=0.
- Read data sampled on the A handshake edge, so Get after Put to same word returns the written data.
- Any other opcode: no write, `d_opcode`=0, `d_data`=0, `d_denied` per Configuration.
- `a_address[2:0]` and address bits above index are ignored for indexing (subject to Configuration).
- Memory contents not reset.

## Timing
- Reset values (rst_n low): state S_IDLE, `a_ready`=0, `d_valid`=0, `d_opcode`=0, `d_size`=0, `d_source`=0, `d_data`=0, `d_denied`=0, `cnt`=0; `a_ready` rises first cycle after deassertion.
- Single outstanding request; `a_ready`=0 in S_WAIT and S_RESP; never concurrent A and D handshakes.
- A handshake at edge E → `d_valid` high after edge E+LATENCY-1 (visible in cycle E+LATENCY).
- D handshake at edge F → `a_ready` high in cycle F+1; minimum request period LATENCY+1 cycles.
- `d_ready` held low: response stalls indefinitely, fields unchanged.
- Reset asserted mid-transaction: pending response discarded, no D beat after reset; a Put already handshaken stays written.

## Configuration
- `TL_SRAM_ERR_EN` defined: request with `a_address[63:3+AW]`≠0, or unsupported opcode, returns `d_denied`=1, `d_data`=0, Get returns AccessAckData with data 0, Put performs no write.
- Undefined: high address bits ignored (address aliases modulo DEPTH*8); `d_denied` tied 0; unsupported opcodes still no-write AccessAck.

## Test plan
- Reset, then Put mask 8'hFF data 64'h1122334455667788 @0x40, Get @0x40 (LATENCY=1) → AccessAckData, `d_data`=64'h1122334455667788, `d_valid` one cycle after A handshake.
- PutPartialData mask 8'h0F data 64'hAAAAAAAA_BBBBBBBB over that word, Get → `d_data`=64'h11223344_BBBBBBBB.
- LATENCY=4, Get source 4'h5 with `d_ready` low 3 cycles → `d_valid` in cycle E+4, fields stable while stalled, `d_source`=5, `a_ready`=0 until cycle after D handshake.
- `a_valid` held through busy window with second Get → accepted only when S_IDLE, responses in order, no lost/duplicated beat.
- Get @ DEPTH*8 (one past end): with `TL_SRAM_ERR_EN` → `d_denied`=1, `d_data`=0; without → aliases to word 0 data.
- rst_n pulsed low in S_WAIT → `d_valid`=0, `a_ready`=0 during reset, `a_ready`=1 next cycle after release, no stray response.
